adc_trigger_ctrl: RTL and testbench

- Parametrised, hysteresis-qualified trigger controller for the ADC sample stream.
- Supports rising, falling or either-edge detection, a programmable output pulse length, holdoff, software force, latched trigger sample and a saturating trigger counter.
- Sits between the ADC capture register and the UART/readout logic, which consumes trig_out and trig_sample.

---
 rtl/adc_trig_pkg.sv | 33 +++
 rtl/trig_threshold.sv | 40 ++++
 rtl/adc_trigger_ctrl.sv | 138 +++++++++++++
 tb/tb_adc_trigger_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_trig_pkg.sv
// Shared types, mode encodings and saturating arithmetic helpers for the
// ADC trigger controller.
package adc_trig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // a + b clamped to the largest w-bit value (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << w) - 33'd1;
        return (sum > max_v) ? max_v[31:0] : sum[31:0];
    endfunction

    // a - b clamped at zero.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (b > a) ? 32'd0 : (a - b);
    endfunction

endpackage

// File: rtl/trig_threshold.sv
// Hysteresis window around the trigger level plus the arm/fire compares
// against the current ADC sample; purely combinational.
module trig_threshold
    import adc_trig_pkg::*;
#(
    parameter int unsigned DATA_W = 14
) (
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] hyst,
    input  logic [1:0]        trig_mode,
    input  logic              arm_r,
    input  logic              arm_f,
    output logic              arm_r_nxt_c,
    output logic              arm_f_nxt_c,
    output logic              rise_c,
    output logic              fall_c
);

    logic [DATA_W-1:0] lo_c;
    logic [DATA_W-1:0] hi_c;
    logic              rise_ok_c;
    logic              fall_ok_c;

    always_comb begin
        lo_c = DATA_W'(sat_sub(32'(trig_level), 32'(hyst)));
        hi_c = DATA_W'(sat_add(32'(trig_level), 32'(hyst), DATA_W));

        rise_ok_c = (trig_mode == MODE_RISE) || (trig_mode == MODE_BOTH);
        fall_ok_c = (trig_mode == MODE_FALL) || (trig_mode == MODE_BOTH);

        // Flags not valid for the current mode drop out on the next update.
        arm_r_nxt_c = rise_ok_c && (arm_r || (adc_in < lo_c));
        arm_f_nxt_c = fall_ok_c && (arm_f || (adc_in > hi_c));

        rise_c = rise_ok_c && arm_r && (adc_in > trig_level);
        fall_c = fall_ok_c && arm_f && (adc_in < trig_level);
    end

endmodule

// File: rtl/adc_trigger_ctrl.sv
// Hysteresis-qualified ADC trigger: edge detect, fixed-length pulse, holdoff,
// software force, latched fire sample and a saturating fire counter.
module adc_trigger_ctrl
    import adc_trig_pkg::*;
#(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned HOLD_W    = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PULSE_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] hyst,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              force_trig,
    input  logic              clr_count,
    output logic              trig_out,
    output logic              trig_dir,
    output logic              trig_forced,
    output logic [DATA_W-1:0] trig_sample,
    output logic [CNT_W-1:0]  trig_count,
    output logic              busy
);

    localparam int unsigned PLS_W = $clog2(PULSE_LEN) + 1;
    localparam int unsigned TMR_W = (HOLD_W > PLS_W) ? HOLD_W : PLS_W;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic               arm_r;
    logic               arm_f;
    logic               arm_r_nxt_c;
    logic               arm_f_nxt_c;
    logic               rise_c;
    logic               fall_c;
    logic               fire_c;

    trig_threshold #(
        .DATA_W (DATA_W)
    ) u_thr (
        .adc_in      (adc_in),
        .trig_level  (trig_level),
        .hyst        (hyst),
        .trig_mode   (trig_mode),
        .arm_r       (arm_r),
        .arm_f       (arm_f),
        .arm_r_nxt_c (arm_r_nxt_c),
        .arm_f_nxt_c (arm_f_nxt_c),
        .rise_c      (rise_c),
        .fall_c      (fall_c)
    );

    assign fire_c = enable && (state == IDLE) && (rise_c || fall_c || force_trig);

    // Trigger FSM; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            arm_r       <= 1'b0;
            arm_f       <= 1'b0;
            trig_out    <= 1'b0;
            busy        <= 1'b0;
            trig_dir    <= 1'b0;
            trig_forced <= 1'b0;
            trig_sample <= '0;
        end else if (!enable) begin
            state    <= IDLE;
            tmr      <= '0;
            arm_r    <= 1'b0;
            arm_f    <= 1'b0;
            trig_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_c) begin
                        state       <= PULSE;
                        tmr         <= TMR_W'(PULSE_LEN - 1);
                        arm_r       <= 1'b0;
                        arm_f       <= 1'b0;
                        trig_out    <= 1'b1;
                        busy        <= 1'b1;
                        trig_sample <= adc_in;
                        trig_dir    <= rise_c;
                        trig_forced <= !(rise_c || fall_c);
                    end else begin
                        arm_r <= arm_r_nxt_c;
                        arm_f <= arm_f_nxt_c;
                    end
                end
                PULSE: begin
                    if (tmr == '0) begin
                        trig_out <= 1'b0;
                        if (holdoff != '0) begin
                            state <= HOLDOFF;
                            tmr   <= TMR_W'(holdoff - HOLD_W'(1));
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (tmr == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    trig_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating fire counter; a clear that coincides with a fire leaves one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_count <= '0;
        end else if (clr_count) begin
            trig_count <= fire_c ? CNT_W'(1) : '0;
        end else if (fire_c && (trig_count != '1)) begin
            trig_count <= trig_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adc_trigger_ctrl.sv
// Directed bench for adc_trigger_ctrl with a 4-bit counter so saturation is reachable.
module tb_adc_trigger_ctrl;

    localparam int unsigned DATA_W    = 14;
    localparam int unsigned HOLD_W    = 16;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned PULSE_LEN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DATA_W-1:0] adc_in;
    logic [1:0]        trig_mode;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] hyst;
    logic [HOLD_W-1:0] holdoff;
    logic              force_trig;
    logic              clr_count;
    logic              trig_out;
    logic              trig_dir;
    logic              trig_forced;
    logic [DATA_W-1:0] trig_sample;
    logic [CNT_W-1:0]  trig_count;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int fires  = 0;
    int hi_cyc = 0;
    logic prev_out = 1'b0;

    adc_trigger_ctrl #(
        .DATA_W    (DATA_W),
        .HOLD_W    (HOLD_W),
        .CNT_W     (CNT_W),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .adc_in      (adc_in),
        .trig_mode   (trig_mode),
        .trig_level  (trig_level),
        .hyst        (hyst),
        .holdoff     (holdoff),
        .force_trig  (force_trig),
        .clr_count   (clr_count),
        .trig_out    (trig_out),
        .trig_dir    (trig_dir),
        .trig_forced (trig_forced),
        .trig_sample (trig_sample),
        .trig_count  (trig_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Counts trig_out rising edges and high cycles just after each active edge.
    always @(posedge clk) begin
        #1;
        if (trig_out === 1'b1) hi_cyc++;
        if (trig_out === 1'b1 && prev_out !== 1'b1) fires++;
        prev_out = trig_out;
    end

    // Present one sample, let one active edge pass, return at the falling edge.
    task automatic feed(input int v);
        adc_in = DATA_W'(v);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; adc_in = '0; trig_mode = 2'b00;
        trig_level = DATA_W'(8000); hyst = DATA_W'(100); holdoff = '0;
        force_trig = 1'b0; clr_count = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL reset_trig_out got %b exp 0", trig_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (trig_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", trig_count); end
        checks++; if (trig_sample !== '0) begin errors++; $display("FAIL reset_sample got %0d exp 0", trig_sample); end
        checks++; if (trig_dir !== 1'b0 || trig_forced !== 1'b0) begin errors++; $display("FAIL reset_flags got dir %b forced %b exp 0 0", trig_dir, trig_forced); end
        rst = 1'b0; enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rise_ramp();
        int f0, h0;
        trig_mode = 2'b00; trig_level = DATA_W'(8000); hyst = DATA_W'(100); holdoff = '0;
        f0 = fires; h0 = hi_cyc;
        for (int v = 7800; v <= 8200; v += 50) begin
            feed(v);
            if (v == 8050) begin
                checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL ramp_fire_8050 got %b exp 1", trig_out); end
            end
            if (v == 8150) begin
                checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL ramp_pulse_end got %b exp 0", trig_out); end
            end
        end
        repeat (3) feed(8200);
        checks++; if (fires - f0 != 1) begin errors++; $display("FAIL ramp_fires got %0d exp 1", fires - f0); end
        checks++; if (hi_cyc - h0 != 2) begin errors++; $display("FAIL ramp_pulse_len got %0d exp 2", hi_cyc - h0); end
        checks++; if (trig_sample !== DATA_W'(8050)) begin errors++; $display("FAIL ramp_sample got %0d exp 8050", trig_sample); end
        checks++; if (trig_dir !== 1'b1 || trig_forced !== 1'b0) begin errors++; $display("FAIL ramp_flags got dir %b forced %b exp 1 0", trig_dir, trig_forced); end
        checks++; if (trig_count !== CNT_W'(1)) begin errors++; $display("FAIL ramp_count got %0d exp 1", trig_count); end
    endtask

    task automatic test_hysteresis();
        int f0;
        f0 = fires;
        for (int i = 0; i < 10; i++) begin
            feed(7950);
            feed(8050);
        end
        checks++; if (fires != f0) begin errors++; $display("FAIL hyst_no_fire got %0d exp 0", fires - f0); end
        feed(7890);
        feed(8050);
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL hyst_rearm_fire got %b exp 1", trig_out); end
        repeat (4) feed(8050);
        checks++; if (fires - f0 != 1) begin errors++; $display("FAIL hyst_fires got %0d exp 1", fires - f0); end
        checks++; if (trig_count !== CNT_W'(2)) begin errors++; $display("FAIL hyst_count got %0d exp 2", trig_count); end
    endtask

    task automatic test_both_edges();
        int f0, n;
        logic p;
        logic [2:0] dirs;
        int seq [4] = '{7900, 8100, 7900, 8100};
        trig_mode = 2'b10; hyst = DATA_W'(50);
        f0 = fires; n = 0; dirs = '0; p = trig_out;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 6; k++) begin
                feed(seq[s]);
                if (trig_out === 1'b1 && p !== 1'b1 && n < 3) begin
                    dirs[n] = trig_dir;
                    n++;
                end
                p = trig_out;
            end
        end
        checks++; if (fires - f0 != 3) begin errors++; $display("FAIL both_fires got %0d exp 3", fires - f0); end
        checks++; if (dirs !== 3'b101) begin errors++; $display("FAIL both_dirs got %b exp 101 (fire0 at lsb)", dirs); end
        checks++; if (trig_count !== CNT_W'(5)) begin errors++; $display("FAIL both_count got %0d exp 5", trig_count); end
    endtask

    task automatic test_holdoff_force();
        int f_idx [2];
        int nf, nb;
        logic p;
        trig_mode = 2'b11; holdoff = HOLD_W'(10); adc_in = DATA_W'(8000);
        nf = 0; nb = 0; p = trig_out; f_idx = '{-1, -1};
        for (int i = 0; i < 24; i++) begin
            force_trig = (i % 4 == 0);
            feed(8000);
            if (i < 16 && busy === 1'b1) nb++;
            if (trig_out === 1'b1 && p !== 1'b1) begin
                if (nf < 2) f_idx[nf] = i;
                nf++;
            end
            p = trig_out;
        end
        force_trig = 1'b0;
        // A force on the closing edge of holdoff (i=12) is dropped; next accepted at i=16.
        checks++; if (nf != 2) begin errors++; $display("FAIL holdoff_fires got %0d exp 2", nf); end
        checks++; if (f_idx[0] != 0 || f_idx[1] != 16) begin errors++; $display("FAIL holdoff_spacing got %0d,%0d exp 0,16", f_idx[0], f_idx[1]); end
        checks++; if (nb != 12) begin errors++; $display("FAIL holdoff_busy_len got %0d exp 12", nb); end
        checks++; if (trig_forced !== 1'b1) begin errors++; $display("FAIL holdoff_forced got %b exp 1", trig_forced); end
        checks++; if (trig_count !== CNT_W'(7)) begin errors++; $display("FAIL holdoff_count got %0d exp 7", trig_count); end
        repeat (16) feed(8000);
        holdoff = '0;
    endtask

    task automatic test_saturate();
        trig_mode = 2'b11;
        clr_count = 1'b1; feed(8000); clr_count = 1'b0;
        checks++; if (trig_count !== '0) begin errors++; $display("FAIL sat_clear got %0d exp 0", trig_count); end
        for (int i = 0; i < 18; i++) begin
            force_trig = 1'b1; feed(8000);
            force_trig = 1'b0; feed(8000); feed(8000);
        end
        checks++; if (trig_count !== CNT_W'(15)) begin errors++; $display("FAIL sat_stick got %0d exp 15", trig_count); end
        clr_count = 1'b1; force_trig = 1'b1; feed(8000);
        clr_count = 1'b0; force_trig = 1'b0;
        checks++; if (trig_count !== CNT_W'(1)) begin errors++; $display("FAIL sat_clr_with_fire got %0d exp 1", trig_count); end
        repeat (3) feed(8000);
    endtask

    task automatic test_force_and_level();
        trig_mode = 2'b00; hyst = DATA_W'(100);
        feed(7800);
        force_trig = 1'b1; feed(8050); force_trig = 1'b0;
        checks++; if (trig_out !== 1'b1 || trig_forced !== 1'b0 || trig_dir !== 1'b1) begin
            errors++; $display("FAIL coincident_flags got out %b forced %b dir %b exp 1 0 1", trig_out, trig_forced, trig_dir);
        end
        checks++; if (trig_count !== CNT_W'(2)) begin errors++; $display("FAIL coincident_count got %0d exp 2", trig_count); end
        repeat (3) feed(8050);
    endtask

    task automatic test_abort();
        int f0;
        trig_mode = 2'b11;
        force_trig = 1'b1; feed(1234); force_trig = 1'b0;
        enable = 1'b0; feed(1234);
        checks++; if (trig_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL disable_abort got out %b busy %b exp 0 0", trig_out, busy); end
        checks++; if (trig_count !== CNT_W'(3)) begin errors++; $display("FAIL disable_count_hold got %0d exp 3", trig_count); end
        checks++; if (trig_sample !== DATA_W'(1234)) begin errors++; $display("FAIL disable_sample_hold got %0d exp 1234", trig_sample); end
        trig_mode = 2'b00; force_trig = 1'b1;
        feed(7800);
        force_trig = 1'b0;
        enable = 1'b1;
        f0 = fires;
        repeat (4) feed(8050);
        checks++; if (fires != f0) begin errors++; $display("FAIL disable_no_rearm got %0d exp 0", fires - f0); end
        trig_mode = 2'b11;
        force_trig = 1'b1; feed(8050); force_trig = 1'b0;
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL rst_pre_pulse got %b exp 1", trig_out); end
        rst = 1'b1; #1;
        checks++; if (trig_out !== 1'b0 || busy !== 1'b0 || trig_count !== '0) begin
            errors++; $display("FAIL rst_mid_pulse got out %b busy %b count %0d exp 0 0 0", trig_out, busy, trig_count);
        end
        @(negedge clk);
        rst = 1'b0;
        trig_mode = 2'b00;
        f0 = fires;
        repeat (4) feed(8050);
        checks++; if (fires != f0 || trig_count !== '0) begin errors++; $display("FAIL rst_no_fire got fires %0d count %0d exp 0 0", fires - f0, trig_count); end
    endtask

    initial begin
        test_reset();
        test_rise_ramp();
        test_hysteresis();
        test_both_edges();
        test_holdoff_force();
        test_saturate();
        test_force_and_level();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
